// File: rtl/dct8_pkg.sv
// Shared constants and the orthonormal 8-point DCT coefficient generator.
// Coefficients are derived from a Q2.30 cosine table rounded to the requested width.
package dct8_pkg;

    localparam int N = 8;

    localparam logic MODE_DCT  = 1'b0;
    localparam logic MODE_IDCT = 1'b1;

    localparam longint C0_Q30 = 64'sd379625062;

    function automatic longint cos_half_q30(input int m);
        longint v;
        unique case (m)
            0:       v = 64'sd536870912;
            1:       v = 64'sd526555088;
            2:       v = 64'sd496004047;
            3:       v = 64'sd446391849;
            4:       v = 64'sd379625062;
            5:       v = 64'sd298269498;
            6:       v = 64'sd205451603;
            7:       v = 64'sd104738319;
            default: v = 64'sd0;
        endcase
        return v;
    endfunction

    // Folds the cosine argument (2n+1)k*pi/16 into the first quadrant.
    function automatic longint dct8_coeff(input int k, input int n, input int cw);
        longint mag;
        int     m;
        int     sh;
        bit     neg;
        m   = ((2 * n + 1) * k) % 32;
        neg = 1'b0;
        if (m > 16) m = 32 - m;
        if (m > 8) begin
            m   = 16 - m;
            neg = 1'b1;
        end
        mag = (k == 0) ? C0_Q30 : cos_half_q30(m);
        sh  = 32 - cw;
        mag = (mag + (64'sd1 <<< (sh - 1))) >>> sh;
        return neg ? -mag : mag;
    endfunction

endpackage

// File: rtl/dct8_dot8.sv
// Registered 8-way signed multiply, adder tree, round-half-up and saturate.
// Two-cycle latency; the result registers hold their value while idle.
module dct8_dot8
    import dct8_pkg::*;
#(
    parameter int DATA_W  = 12,
    parameter int COEFF_W = 16,
    parameter int OUT_W   = 18
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      valid_in,
    input  logic [2:0]                idx_in,
    input  logic signed [DATA_W-1:0]  x [N],
    input  logic signed [COEFF_W-1:0] c [N],
    output logic                      valid_out,
    output logic [2:0]                idx_out,
    output logic signed [OUT_W-1:0]   y
);

    localparam int PW = DATA_W + COEFF_W;
    localparam int AW = PW + 3;
    localparam int SH = COEFF_W - 2;

    localparam logic signed [AW-1:0] HALF = AW'(1) <<< (SH - 1);
    localparam logic signed [OUT_W-1:0] OMAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] OMIN = {1'b1, {(OUT_W-1){1'b0}}};

    logic signed [PW-1:0]    prod_q [N];
    logic                    pv_q;
    logic [2:0]              pidx_q;
    logic signed [AW-1:0]    sum;
    logic signed [AW-1:0]    rnd;
    logic signed [OUT_W-1:0] sat;

    always_ff @(posedge clk) begin
        if (rst) begin
            pv_q   <= 1'b0;
            pidx_q <= '0;
            for (int i = 0; i < N; i++) prod_q[i] <= '0;
        end else begin
            pv_q <= valid_in;
            if (valid_in) begin
                pidx_q <= idx_in;
                for (int i = 0; i < N; i++)
                    prod_q[i] <= PW'(x[i]) * PW'(c[i]);
            end
        end
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < N; i++) sum = sum + AW'(prod_q[i]);
        rnd = (sum + HALF) >>> SH;
        if (rnd > AW'(OMAX))
            sat = OMAX;
        else if (rnd < AW'(OMIN))
            sat = OMIN;
        else
            sat = rnd[OUT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out <= 1'b0;
            idx_out   <= '0;
            y         <= '0;
        end else begin
            valid_out <= pv_q;
            if (pv_q) begin
                idx_out <= pidx_q;
                y       <= sat;
            end
        end
    end

endmodule

// File: rtl/dct1d_8_pipeline.sv
// Streaming 8-point forward/inverse DCT: sample buffer, block snapshot,
// coefficient row/column selection and the 8-cycle result emitter.
module dct1d_8_pipeline
    import dct8_pkg::*;
#(
    parameter int DATA_W  = 12,
    parameter int COEFF_W = 16,
    parameter int OUT_W   = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              valid_in,
    input  logic              mode,
    input  logic [2:0]        index,
    output logic [OUT_W-1:0]  coeff_out,
    output logic              valid_out,
    output logic [2:0]        index_out
);

    logic signed [DATA_W-1:0]  xbuf_q [N];
    logic signed [DATA_W-1:0]  comp_q [N];
    logic signed [DATA_W-1:0]  work_q [N];
    logic signed [COEFF_W-1:0] ctab   [N][N];
    logic signed [COEFF_W-1:0] coef   [N];
    logic signed [OUT_W-1:0]   y;
    logic                      comp_mode_q;
    logic                      work_mode_q;
    logic                      go_q;
    logic                      sel_v_q;
    logic [2:0]                sel_idx_q;
    logic                      trig;

    assign trig = valid_in && (index == 3'd7);

    for (genvar k = 0; k < N; k++) begin : g_k
        for (genvar n = 0; n < N; n++) begin : g_n
            assign ctab[k][n] = COEFF_W'(dct8_coeff(k, n, COEFF_W));
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++)
            coef[i] = (work_mode_q == MODE_IDCT) ? ctab[i][sel_idx_q]
                                                 : ctab[sel_idx_q][i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) xbuf_q[i] <= '0;
        end else if (valid_in) begin
            xbuf_q[index] <= sample_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) comp_q[i] <= '0;
            comp_mode_q <= MODE_DCT;
            go_q        <= 1'b0;
        end else begin
            go_q <= trig;
            if (trig) begin
                for (int i = 0; i < N - 1; i++) comp_q[i] <= xbuf_q[i];
                comp_q[N-1] <= sample_in;
                comp_mode_q <= mode;
            end
        end
    end

    // A second copy keeps the tail of a running block intact while the next one lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) work_q[i] <= '0;
            work_mode_q <= MODE_DCT;
            sel_v_q     <= 1'b0;
            sel_idx_q   <= '0;
        end else if (go_q) begin
            work_q      <= comp_q;
            work_mode_q <= comp_mode_q;
            sel_v_q     <= 1'b1;
            sel_idx_q   <= '0;
        end else if (sel_v_q) begin
            sel_idx_q <= sel_idx_q + 3'd1;
            if (sel_idx_q == 3'd7) sel_v_q <= 1'b0;
        end
    end

    dct8_dot8 #(
        .DATA_W  (DATA_W),
        .COEFF_W (COEFF_W),
        .OUT_W   (OUT_W)
    ) u_dot8 (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (sel_v_q),
        .idx_in    (sel_idx_q),
        .x         (work_q),
        .c         (coef),
        .valid_out (valid_out),
        .idx_out   (index_out),
        .y         (y)
    );

    assign coeff_out = y;

endmodule

// File: tb/tb_dct1d_8_pipeline.sv
// Directed bench for dct1d_8_pipeline with hand-computed expected results.
module tb_dct1d_8_pipeline;
    import dct8_pkg::*;

    localparam int DW = 12;
    localparam int CW = 16;
    localparam int OW = 18;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          valid_in = 1'b0;
    logic          mode = 1'b0;
    logic [DW-1:0] sample_in = '0;
    logic [2:0]    index = '0;
    logic [OW-1:0] coeff_out;
    logic          valid_out;
    logic [2:0]    index_out;

    int vectors = 0;
    int miscompares = 0;

    logic signed [DW-1:0] v [8];
    logic signed [OW-1:0] ex [16];
    int ord [8];
    int seq [8];

    always #5 clk = ~clk;

    dct1d_8_pipeline #(
        .DATA_W  (DW),
        .COEFF_W (CW),
        .OUT_W   (OW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sample_in (sample_in),
        .valid_in  (valid_in),
        .mode      (mode),
        .index     (index),
        .coeff_out (coeff_out),
        .valid_out (valid_out),
        .index_out (index_out)
    );

    task automatic chk(input string tag, input logic ev, input logic [2:0] ei,
                       input logic signed [OW-1:0] ev_val);
        vectors++;
        assert (valid_out === ev && index_out === ei && coeff_out === ev_val)
        else begin
            miscompares++;
            $error("FAIL %s: observed v=%b idx=%0d val=%0d, expected v=%b idx=%0d val=%0d",
                   tag, valid_out, index_out, $signed(coeff_out), ev, ei, ev_val);
        end
    endtask

    task automatic chk_v(input string tag, input logic ev);
        vectors++;
        assert (valid_out === ev)
        else begin
            miscompares++;
            $error("FAIL %s: observed valid_out=%b, expected %b", tag, valid_out, ev);
        end
    endtask

    task automatic send(input logic signed [DW-1:0] d [8], input int o [8],
                        input logic m, input bit hold);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            valid_in  = 1'b1;
            index     = 3'(o[i]);
            sample_in = d[o[i]];
            mode      = m;
        end
        if (!hold) begin
            @(negedge clk);
            valid_in = 1'b0;
        end
    endtask

    task automatic collect(input logic signed [OW-1:0] e [16], input int n,
                           input int budget, input string tag);
        int w = 0;
        while (valid_out !== 1'b1 && w < budget) begin
            @(negedge clk);
            w++;
        end
        vectors++;
        assert (valid_out === 1'b1)
        else begin
            miscompares++;
            $error("FAIL %s start: observed valid_out=%b after %0d cycles, expected 1",
                   tag, valid_out, w);
        end
        if (valid_out !== 1'b1) return;
        for (int j = 0; j < n; j++) begin
            chk($sformatf("%s[%0d]", tag, j), 1'b1, 3'(j % 8), e[j]);
            @(negedge clk);
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) seq[i] = i;

        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset", 1'b0, 3'd0, '0);
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk_v("quiet_after_reset", 1'b0);
        end

        v = '{default: 12'sd100};
        send(v, seq, MODE_DCT, 1'b0);
        chk_v("lat0", 1'b0);
        @(negedge clk);
        chk_v("lat1", 1'b0);
        @(negedge clk);
        chk_v("lat2", 1'b0);
        @(negedge clk);
        ex = '{default: 18'sd0};
        ex[0] = 18'sd283;
        collect(ex, 8, 0, "dc_dct");
        chk_v("dc_dct_idle", 1'b0);

        v = '{default: 12'sd0};
        v[0] = 12'sd283;
        send(v, seq, MODE_IDCT, 1'b0);
        ex = '{default: 18'sd100};
        collect(ex, 8, 5, "dc_idct");

        v = '{default: -12'sd100};
        send(v, seq, MODE_DCT, 1'b0);
        ex = '{default: 18'sd0};
        ex[0] = -18'sd283;
        collect(ex, 8, 5, "neg_dc");

        v = '{default: 12'sd0};
        v[0] = 12'sd64;
        send(v, seq, MODE_DCT, 1'b0);
        ex = '{default: 18'sd0};
        ex[0] = 18'sd23; ex[1] = 18'sd31; ex[2] = 18'sd30; ex[3] = 18'sd27;
        ex[4] = 18'sd23; ex[5] = 18'sd18; ex[6] = 18'sd12; ex[7] = 18'sd6;
        collect(ex, 8, 5, "imp_dct");

        v[0] = 12'sd23; v[1] = 12'sd31; v[2] = 12'sd30; v[3] = 12'sd27;
        v[4] = 12'sd23; v[5] = 12'sd18; v[6] = 12'sd12; v[7] = 12'sd6;
        send(v, seq, MODE_IDCT, 1'b0);
        ex = '{default: 18'sd0};
        ex[0] = 18'sd64;
        ex[2] = -18'sd1;
        collect(ex, 8, 5, "imp_idct");

        v = '{default: 12'sd0};
        v[3] = 12'sd64;
        ord = '{3, 0, 5, 1, 6, 2, 4, 7};
        send(v, ord, MODE_DCT, 1'b0);
        ex = '{default: 18'sd0};
        ex[0] = 18'sd23;  ex[1] = 18'sd6;   ex[2] = -18'sd30; ex[3] = -18'sd18;
        ex[4] = 18'sd23;  ex[5] = 18'sd27;  ex[6] = -18'sd12; ex[7] = -18'sd31;
        collect(ex, 8, 5, "out_of_order");

        v = '{default: 12'sd0};
        v[0] = 12'sd64;
        send(v, seq, MODE_DCT, 1'b0);
        repeat (3) @(negedge clk);
        chk("retrig_old0", 1'b1, 3'd0, 18'sd23);
        valid_in  = 1'b1;
        index     = 3'd7;
        sample_in = '0;
        mode      = MODE_IDCT;
        @(negedge clk);
        valid_in = 1'b0;
        chk("retrig_old1", 1'b1, 3'd1, 18'sd31);
        @(negedge clk);
        chk("retrig_old2", 1'b1, 3'd2, 18'sd30);
        @(negedge clk);
        chk("retrig_old3", 1'b1, 3'd3, 18'sd27);
        @(negedge clk);
        ex = '{default: 18'sd23};
        collect(ex, 8, 0, "retrig_new");
        chk_v("retrig_idle", 1'b0);

        v = '{default: 12'sd100};
        send(v, seq, MODE_DCT, 1'b0);
        repeat (3) @(negedge clk);
        chk("rstmid_0", 1'b1, 3'd0, 18'sd283);
        @(negedge clk);
        chk("rstmid_1", 1'b1, 3'd1, 18'sd0);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_drop", 1'b0, 3'd0, '0);
        rst = 1'b0;
        repeat (12) begin
            @(negedge clk);
            chk_v("rstmid_quiet", 1'b0);
        end

        v = '{default: 12'sd100};
        send(v, seq, MODE_DCT, 1'b1);
        v = '{default: -12'sd100};
        ex = '{default: 18'sd0};
        ex[0] = 18'sd283;
        ex[8] = -18'sd283;
        fork
            send(v, seq, MODE_DCT, 1'b0);
            collect(ex, 16, 10, "b2b");
        join
        chk_v("b2b_idle", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
